// File: rtl/alu_cmd_master.sv
// Command front-end for an external combinational ALU: accepts one command,
// drives registered operands for one cycle, captures the result and returns it.
module alu_cmd_master (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_sel,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_chain,
  input  logic [1:0] cmd_tag,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [4:0] alu_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_y,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic [1:0] rsp_tag,
  output logic [7:0] op_count
);

  localparam int unsigned W_OP  = 4;
  localparam int unsigned W_Y   = 5;
  localparam int unsigned W_SEL = 3;
  localparam int unsigned W_TAG = 2;
  localparam int unsigned W_CNT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   capture;
  logic   retire;

  // Only the low operand bits of the previous result are ever chained.
  logic [W_OP-1:0] last_y;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags track the next state so they are registered yet cycle-exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_y     <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b1;
      rsp_tag   <= '0;
      last_y    <= '0;
      op_count  <= '0;
    end else begin
      cmd_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      if (accept) begin
        alu_a   <= cmd_chain ? last_y : cmd_a;
        alu_b   <= cmd_b;
        alu_sel <= cmd_sel;
        rsp_tag <= cmd_tag;
      end
      if (capture) begin
        rsp_y     <= alu_y;
        rsp_carry <= alu_y[W_Y-1];
        rsp_zero  <= (alu_y == W_Y'(0));
        last_y    <= alu_y[W_OP-1:0];
      end
      if (retire) op_count <= op_count + W_CNT'(1);
    end
  end

  // Widths of the command fields are fixed by the port list; keep them tied.
  localparam int unsigned W_CHK = W_SEL + W_TAG;
  if (W_CHK != 5) begin : g_width_guard
    $error("unexpected field widths");
  end

endmodule

// File: doc/alu_cmd_master.md
ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  synchronous, active-high reset.
REQ-003: cmd_valid  input  1  command present.
REQ-004: cmd_ready  output  1  block can accept a command.
REQ-005: cmd_sel  input  3  ALU opcode: 000 add, 001 sub, 010 inc a, 011 dec b, 100 and, 101 or, 110 xor, 111 not b.
REQ-006: cmd_a, cmd_b  input  4 each  operands.
REQ-007: cmd_chain  input  1  when 1, operand a is replaced by last_y[3:0].
REQ-008: cmd_tag  input  2  opaque ID returned with the response.
REQ-009: alu_a, alu_b  output  4 each  registered operands to the external combinational ALU.
REQ-010: alu_sel  output  3  registered opcode to the ALU.
REQ-011: alu_y  input  5  ALU result, combinational from alu_a, alu_b and alu_sel.
REQ-012: rsp_valid  output  1  response present.
REQ-013: rsp_ready  input  1  consumer accepts the response.
REQ-014: rsp_y  output  5  captured result.
REQ-015: rsp_carry  output  1  equals rsp_y[4].
REQ-016: rsp_zero  output  1  1 when rsp_y == 5'b00000.
REQ-017: rsp_tag  output  2  tag of the command.
REQ-018: op_count  output  8  number of completed responses.

Function
REQ-019: The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-020: cmd_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-021: IDLE->EXEC on cmd_valid&&cmd_ready; on that edge the block SHALL load alu_a (cmd_chain ? last_y[3:0] : cmd_a), alu_b=cmd_b, alu_sel=cmd_sel and the tag.
REQ-022: EXEC SHALL last exactly one cycle; on its closing edge the block SHALL capture rsp_y=alu_y and last_y=alu_y, then go to RESP.
REQ-023: RESP->IDLE on rsp_valid&&rsp_ready; op_count SHALL increment on that edge, wrapping 255->0.
REQ-024: Latency SHALL be fixed: command accepted at edge N, rsp_valid high from the cycle after edge N+1; minimum 3 cycles per command.
REQ-025: While in RESP with rsp_ready=0, rsp_y, rsp_carry, rsp_zero and rsp_tag SHALL hold stable and no new command SHALL be accepted.
REQ-026: alu_a, alu_b and alu_sel SHALL hold their last values in IDLE and RESP.
REQ-027: cmd_* inputs SHALL be ignored outside the accept edge; cmd_valid in EXEC or RESP SHALL have no effect.
REQ-028: rsp_carry SHALL be taken from rsp_y[4] directly (carry for add/inc; 5-bit wrap/borrow for sub/dec; 0 for logic ops); no extra arithmetic SHALL be done in this block.
REQ-029: last_y SHALL update only on the EXEC closing edge, so consecutive chained commands each see the previous result.

Reset
REQ-030: With rst=1 at a rising edge, the block SHALL enter IDLE and clear alu_a, alu_b, alu_sel, rsp_y, rsp_tag, last_y and op_count to 0, giving rsp_valid=0, rsp_zero=1, rsp_carry=0 and cmd_ready=1 in the next cycle.
REQ-031: Reset SHALL take priority over any handshake on the same edge; a command in EXEC or RESP SHALL be discarded without a response or op_count increment.

Verification
REQ-032: add a=9, b=8, tag=2 -> rsp_y=10001, carry=1, zero=0, tag=2; rsp_valid rises exactly 2 edges after accept.
REQ-033: sub a=3, b=5 -> rsp_y=11110, carry=1; then xor a=5, b=5 -> rsp_y=00000, zero=1, carry=0.
REQ-034: add 9+8, then chained inc a with cmd_a=7 -> alu_a=0001, rsp_y=00010; not b with b=0 -> rsp_y=01111.
REQ-035: hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp fields stable, cmd_ready=0, op_count unchanged until the release edge.
REQ-036: assert rst during EXEC, then during RESP -> no response, op_count=0, cmd_ready=1 next cycle, last_y=0 so a chained add with b=3 gives rsp_y=00011.
REQ-037: issue 257 back-to-back commands with rsp_ready=1 -> op_count reads 1; every command takes exactly 3 cycles.
